// File: rtl/qspi_ram_bridge.sv
// Quad-SPI slave bridging host nibble traffic onto a shared byte RAM.
// Pins are oversampled in the clk domain; writes are single-cycle strobes, reads are prefetched.
`timescale 1ns/1ps
module qspi_ram_bridge #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DUMMY_CYCLES = 2,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  qspi_sck,
  input  logic                  qspi_cs_n,
  input  logic [3:0]            qspi_io_in,
  output logic [3:0]            qspi_io_out,
  output logic                  qspi_io_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wen,
  input  logic [7:0]            ram_rdata,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h32;
  localparam logic [7:0] CMD_READ  = 8'h6B;

  state_t                state;
  logic                  sck_s1, sck_s2, sck_d;
  logic                  cs_s1, cs_s2, cs_d;
  logic [3:0]            io_s1, io_s2;
  logic                  wr_flag;
  logic                  nib_odd;
  logic [3:0]            hi_nib;
  logic [3:0]            lo_nib;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]            dcnt;
  logic [2:0]            rd_cnt;
  logic [7:0]            nxt_byte;

  logic                  sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]            in_byte;
  logic [ADDR_WIDTH-1:0] in_addr;

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_rise  = cs_s2 & ~cs_d;
  // Frames start on a cs_n fall so a frame cut by reset is not re-parsed mid-stream.
  assign cs_fall  = ~cs_s2 & cs_d;
  assign in_byte  = {hi_nib, io_s2};
  assign in_addr  = in_byte[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sck_s1      <= 1'b0;
      sck_s2      <= 1'b0;
      sck_d       <= 1'b0;
      cs_s1       <= 1'b0;
      cs_s2       <= 1'b0;
      cs_d        <= 1'b0;
      io_s1       <= '0;
      io_s2       <= '0;
      wr_flag     <= 1'b0;
      nib_odd     <= 1'b0;
      hi_nib      <= '0;
      lo_nib      <= '0;
      addr_reg    <= '0;
      dcnt        <= '0;
      rd_cnt      <= '0;
      nxt_byte    <= '0;
      qspi_io_out <= '0;
      qspi_io_oe  <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wen     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      sck_s1     <= qspi_sck;
      sck_s2     <= sck_s1;
      sck_d      <= sck_s2;
      cs_s1      <= qspi_cs_n;
      cs_s2      <= cs_s1;
      cs_d       <= cs_s2;
      io_s1      <= qspi_io_in;
      io_s2      <= io_s1;
      ram_wen    <= 1'b0;
      frame_done <= 1'b0;

      if (rd_cnt != '0) begin
        rd_cnt <= rd_cnt - 3'd1;
        if (rd_cnt == 3'd1)
          nxt_byte <= ram_rdata;
      end

      if (cs_rise) begin
        state       <= IDLE;
        qspi_io_oe  <= 1'b0;
        qspi_io_out <= '0;
        frame_done  <= ((state == WDATA) || (state == RDATA)) && !nib_odd;
        nib_odd     <= 1'b0;
        rd_cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              nib_odd <= 1'b0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                hi_nib <= io_s2;
              end else if (in_byte == CMD_WRITE) begin
                state   <= ADDR;
                wr_flag <= 1'b1;
              end else if (in_byte == CMD_READ) begin
                state   <= ADDR;
                wr_flag <= 1'b0;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                hi_nib <= io_s2;
              end else if (wr_flag) begin
                state    <= WDATA;
                addr_reg <= in_addr;
              end else begin
                state    <= DUMMY;
                dcnt     <= '0;
                ram_addr <= in_addr;
                addr_reg <= in_addr + 1'b1;
                rd_cnt   <= 3'(RD_LAT + 1);
              end
            end
          end
          WDATA: begin
            if (sck_rise) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                hi_nib <= io_s2;
              end else begin
                ram_wen   <= 1'b1;
                ram_addr  <= addr_reg;
                ram_wdata <= in_byte;
                addr_reg  <= addr_reg + 1'b1;
              end
            end
          end
          DUMMY: begin
            if (sck_rise) begin
              if (dcnt == 4'(DUMMY_CYCLES - 1)) begin
                state      <= RDATA;
                qspi_io_oe <= 1'b1;
                nib_odd    <= 1'b0;
              end else begin
                dcnt <= dcnt + 4'd1;
              end
            end
          end
          RDATA: begin
            if (sck_fall) begin
              nib_odd <= ~nib_odd;
              if (!nib_odd) begin
                qspi_io_out <= nxt_byte[7:4];
                lo_nib      <= nxt_byte[3:0];
              end else begin
                // Low nibble goes out; fetch the following byte while it is on the bus.
                qspi_io_out <= lo_nib;
                ram_addr    <= addr_reg;
                addr_reg    <= addr_reg + 1'b1;
                rd_cnt      <= 3'(RD_LAT + 1);
              end
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_ram_bridge.sv
// Bench for qspi_ram_bridge: table-driven write frames, hand-written read/reset sequences,
// and randomized write/read-back frames checked against a byte-array RAM model.
`timescale 1ns/1ps
module tb_qspi_ram_bridge;

  localparam int unsigned AW   = 8;
  localparam int unsigned DC   = 2;
  localparam int unsigned RL   = 1;
  localparam time         HALF = 80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          qspi_sck = 1'b0;
  logic          qspi_cs_n = 1'b1;
  logic [3:0]    qspi_io_in = '0;
  logic [3:0]    qspi_io_out;
  logic          qspi_io_oe;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_wen;
  logic [7:0]    ram_rdata;
  logic          frame_done;

  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [7:0]    pl_data = '0;
  logic [7:0]    mem [256];

  logic [15:0]   wlog[$];
  int            done_total = 0;

  logic [7:0]    ref_mem [256];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  qspi_ram_bridge #(
    .ADDR_WIDTH  (AW),
    .DUMMY_CYCLES(DC),
    .RD_LAT      (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .qspi_sck   (qspi_sck),
    .qspi_cs_n  (qspi_cs_n),
    .qspi_io_in (qspi_io_in),
    .qspi_io_out(qspi_io_out),
    .qspi_io_oe (qspi_io_oe),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wen    (ram_wen),
    .ram_rdata  (ram_rdata),
    .frame_done (frame_done)
  );

  // Synchronous RAM, one clk read latency.
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (ram_wen)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_wen)
      wlog.push_back({ram_addr, ram_wdata});
    if (frame_done)
      done_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    qspi_io_in = n;
    #HALF qspi_sck = 1'b1;
    #HALF qspi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic cs_start();
    qspi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF qspi_cs_n = 1'b1;
    #(HALF * 3);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    #10 pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Sends one frame and compares RAM writes against what the command/address/bytes imply.
  task automatic write_frame(input string tag, input logic [7:0] cmd, input logic [7:0] a,
                             input int n, input logic [71:0] d, input logic extra,
                             input int exp_nwr, input int exp_done);
    int          wbase, dbase, nmodel, oe_seen;
    logic [15:0] exp_w[$];
    logic [7:0]  b;
    wbase   = wlog.size();
    dbase   = done_total;
    oe_seen = 0;
    cs_start();
    send_byte(cmd);
    send_byte(a);
    for (int i = 0; i < n; i++) begin
      b = d[71 - 8*i -: 8];
      send_byte(b);
      if (qspi_io_oe) oe_seen++;
      if (cmd == 8'h32) begin
        exp_w.push_back({8'((a + i) % 256), b});
        ref_mem[(a + i) % 256] = b;
      end
    end
    if (extra) nib(4'hE);
    cs_end();
    nmodel = exp_w.size();
    check({tag, " nwr"}, 32'(wlog.size() - wbase), 32'(exp_nwr));
    for (int i = 0; i < nmodel && (wbase + i) < wlog.size(); i++)
      check({tag, " wr"}, 32'(wlog[wbase + i]), 32'(exp_w[i]));
    check({tag, " done"}, 32'(done_total - dbase), 32'(exp_done));
    check({tag, " oe"}, 32'(oe_seen + int'(qspi_io_oe)), 32'd0);
  endtask

  // Read frame of n bytes; each nibble checked against the RAM model.
  task automatic read_frame(input string tag, input logic [7:0] a, input int n);
    int         wbase, dbase, oe_miss;
    logic [3:0] got;
    logic [7:0] eb;
    wbase   = wlog.size();
    dbase   = done_total;
    oe_miss = 0;
    cs_start();
    send_byte(8'h6B);
    send_byte(a);
    check({tag, " oe pre"}, 32'(qspi_io_oe), 32'd0);
    for (int i = 0; i < int'(DC); i++) nib(4'h0);
    for (int k = 0; k < 2 * n; k++) begin
      #HALF;
      got = qspi_io_out;
      if (!qspi_io_oe) oe_miss++;
      eb = ref_mem[(a + k / 2) % 256];
      check({tag, " nib"}, 32'(got), (k % 2 == 0) ? 32'(eb[7:4]) : 32'(eb[3:0]));
      qspi_sck = 1'b1;
      #HALF;
      if (k == 2 * n - 1) begin
        qspi_cs_n = 1'b1;
        #HALF;
      end
      qspi_sck = 1'b0;
    end
    #(HALF * 2);
    check({tag, " oe data"}, 32'(oe_miss), 32'd0);
    check({tag, " nowr"}, 32'(wlog.size() - wbase), 32'd0);
    check({tag, " done"}, 32'(done_total - dbase), 32'd1);
    check({tag, " idle"}, {27'd0, qspi_io_oe, qspi_io_out}, 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [3:0]  nbytes;
    logic [71:0] data;
    logic        extra;
    logic [3:0]  exp_nwr;
    logic        exp_done;
  } wvec_t;

  initial begin
    #(HALF * 400_00);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    wvec_t       vecs [6];
    logic [7:0]  ra;
    int          rn;
    logic [71:0] rd;
    int          wbase, dbase;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    vecs[0] = '{8'h32, 8'h00, 4'd9, 72'h3F8000004000000001, 1'b0, 4'd9, 1'b1};
    vecs[1] = '{8'h32, 8'hFF, 4'd2, {8'hAA, 8'hBB, 56'h0},   1'b0, 4'd2, 1'b1};
    vecs[2] = '{8'h32, 8'h05, 4'd1, {8'hCD, 64'h0},          1'b1, 4'd1, 1'b0};
    vecs[3] = '{8'hA5, 8'h12, 4'd4, {32'h12345678, 40'h0},   1'b0, 4'd0, 1'b0};
    vecs[4] = '{8'h32, 8'h20, 4'd3, {24'h112233, 48'h0},     1'b0, 4'd3, 1'b1};
    vecs[5] = '{8'h32, 8'h30, 4'd0, 72'h0,                   1'b0, 4'd0, 1'b1};

    #52;
    check("reset state", {17'd0, qspi_io_out, qspi_io_oe, ram_addr, ram_wen, frame_done},
          32'd0);
    rst = 1'b0;
    #(HALF * 2);

    for (int v = 0; v < 6; v++)
      write_frame($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].addr, int'(vecs[v].nbytes),
                  vecs[v].data, vecs[v].extra, int'(vecs[v].exp_nwr), int'(vecs[v].exp_done));

    preload(8'h10, 8'h40);
    preload(8'h11, 8'h40);
    preload(8'h12, 8'h00);
    preload(8'h13, 8'h00);
    read_frame("rd10", 8'h10, 4);

    // Reset pulse in the middle of the second nibble of a data byte.
    wbase = wlog.size();
    dbase = done_total;
    cs_start();
    send_byte(8'h32);
    send_byte(8'h40);
    nib(4'h7);
    qspi_io_in = 4'h3;
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    check("rst outputs", {7'd0, qspi_io_out, qspi_io_oe, ram_addr, ram_wdata, ram_wen, frame_done},
          32'd0);
    #7;
    #(HALF - 20) qspi_sck = 1'b1;
    #HALF qspi_sck = 1'b0;
    cs_end();
    check("rst nowr", 32'(wlog.size() - wbase), 32'd0);
    check("rst nodone", 32'(done_total - dbase), 32'd0);
    write_frame("post rst", 8'h32, 8'h41, 1, {8'h5A, 64'h0}, 1'b0, 1, 1);

    for (int it = 0; it < 6; it++) begin
      ra = 8'($urandom);
      rn = int'($urandom_range(1, 5));
      rd = {$urandom(), $urandom(), 8'($urandom())};
      write_frame($sformatf("rnd%0d w", it), 8'h32, ra, rn, rd, 1'b0, rn, 1);
      read_frame($sformatf("rnd%0d r", it), ra, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
